// File: rtl/uram_stream_reader.sv
// Streaming read engine for a pipelined URAM port: issues one read per cycle for a
// (base, len) command and presents returned words as a valid/ready stream with last.
module uram_stream_reader #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 32,
    parameter int READ_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W  = (CW+1)'(FIFO_DEPTH);
    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
    localparam logic [AWIDTH:0]   REM_ONE  = (AWIDTH+1)'(1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);

    if (FIFO_DEPTH < READ_LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uram_stream_reader: FIFO_DEPTH must be a power of 2 and >= READ_LAT+1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state_r, state_s;
    logic [AWIDTH-1:0]   addr_r;
    logic [AWIDTH:0]     remaining_r;
    logic                mem_en_r, issue_last_r, busy_r, done_r;
    logic [AWIDTH-1:0]   mem_addr_r;
    logic [READ_LAT-1:0] vld_sr_r, last_sr_r;
    logic [DWIDTH-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_r;
    logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]       count_r, out_r;
    logic                issue_s, push_s, pop_s, credit_s, valid_s;

    assign valid_s  = (count_r != '0);
    assign push_s   = vld_sr_r[READ_LAT-1];
    assign pop_s    = valid_s && m_ready;
    // Words being popped this cycle are deliberately not credited back.
    assign credit_s = ({1'b0, out_r} + {1'b0, count_r}) < DEPTH_W;

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_en   = mem_en_r;
    assign mem_we   = 1'b0;
    assign mem_addr = mem_addr_r;
    assign m_valid  = valid_s;
    assign m_data   = fifo_data_r[rd_ptr_r];
    assign m_last   = valid_s && fifo_last_r[rd_ptr_r];

    // Next-state and issue decision.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && len != '0) state_s = ISSUE;
                else                    state_s = IDLE;
            end
            ISSUE: begin
                if (credit_s) begin
                    issue_s = 1'b1;
                    if (remaining_r == REM_ONE) state_s = DRAIN;
                    else                        state_s = ISSUE;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && m_last) state_s = IDLE;
                else                 state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Command state, address generation and registered URAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            addr_r       <= '0;
            remaining_r  <= '0;
            mem_en_r     <= 1'b0;
            mem_addr_r   <= '0;
            issue_last_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_r == IDLE && start && len == '0) ||
                            (state_r == DRAIN && pop_s && m_last);
            mem_en_r     <= issue_s;
            issue_last_r <= issue_s && (remaining_r == REM_ONE);
            if (state_r == IDLE && start && len != '0) begin
                addr_r      <= base_addr;
                remaining_r <= len;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_ONE;
                remaining_r <= remaining_r - REM_ONE;
            end
            if (issue_s) mem_addr_r <= addr_r;
        end
    end

    // Valid/last pipeline tracking the URAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_r  <= '0;
            last_sr_r <= '0;
        end else begin
            vld_sr_r[0]  <= mem_en_r;
            last_sr_r[0] <= issue_last_r;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_sr_r[i]  <= vld_sr_r[i-1];
                last_sr_r[i] <= last_sr_r[i-1];
            end
        end
    end

    // Output FIFO and outstanding-read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_r[i] <= '0;
            fifo_last_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_r       <= '0;
        end else begin
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
            out_r   <= out_r + CW'(issue_s) - CW'(push_s);
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= mem_dout;
                fifo_last_r[wr_ptr_r] <= last_sr_r[READ_LAT-1];
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_uram_stream_reader.sv
// Directed/randomized bench for uram_stream_reader with a URAM latency model and an
// expected-beat queue built from memory contents and command (base, len).
module tb_uram_stream_reader;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam int FD = 8;

    logic          clk, rst, start, busy, done, mem_en, mem_we, m_valid, m_ready, m_last;
    logic [AW-1:0] base_addr, mem_addr;
    logic [AW:0]   len;
    logic [DW-1:0] mem_dout, m_data;

    uram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW), .READ_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // URAM model: data sampled with en/addr appears READ_LAT edges later.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= mem_en ? mem[mem_addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[RL-1];

    typedef struct {logic [DW-1:0] d; logic l;} beat_t;
    beat_t exp_q[$];
    logic [AW-1:0] addr_log[$];
    int pop_cyc_q[$];
    int done_cyc_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int en_cnt = 0, pop_cnt = 0, last_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int inflight = 0, max_inflight = 0;
    int rdy_mode = 0;
    bit stalled_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic prev_l;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_q.push_back('{d: mem[a], l: (i == n - 1)});
        end
    endtask

    task automatic do_cmd(input logic [AW-1:0] b, input int n, input bit model);
        step();
        start = 1'b1;
        base_addr = b;
        len = (AW+1)'(n);
        if (model) push_expected(b, n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Stream monitor: compares every handshake against the expected-beat queue.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rst) begin
            stalled_prev = 1'b0;
            inflight = 0;
        end else begin
            if (stalled_prev && m_valid) begin
                chk("stall_data_stable", 64'(m_data), 64'(prev_d));
                chk("stall_last_stable", 64'(m_last), 64'(prev_l));
            end
            if (mem_en) begin
                en_cnt++;
                addr_log.push_back(mem_addr);
                inflight++;
            end
            if (m_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                pop_cnt++;
                inflight--;
                pop_cyc_q.push_back(cyc);
                if (m_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_data), 64'(e.d));
                    chk("beat_last", 64'(m_last), 64'(e.l));
                end
            end
            if (inflight > max_inflight) max_inflight = inflight;
            stalled_prev = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    initial begin
        int n, en0, p0, l0, d0, v0, pc0;
        logic [AW-1:0] b;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'h0000_00A0 + 32'(i);

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        chk("mem_we_zero", 64'(mem_we), 64'd0);
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Basic read with latency and back-to-back beats
        rdy_mode = 0;
        pc0 = pop_cyc_q.size();
        l0 = last_cnt;
        do_cmd(12'h010, 4, 1'b1);
        chk("basic_busy", 64'(busy), 64'd1);
        @(negedge clk);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("basic_first_valid_latency", 64'(n), 64'd5);
        wait_done(40, "basic_done");
        chk("basic_beats", 64'(pop_cyc_q.size() - pc0), 64'd4);
        if (pop_cyc_q.size() - pc0 == 4) begin
            chk("basic_consecutive", 64'(pop_cyc_q[pc0+3] - pop_cyc_q[pc0]), 64'd3);
            chk("basic_done_after_last", 64'(done_cyc_q[done_cyc_q.size()-1]),
                64'(pop_cyc_q[pc0+3] + 1));
        end
        chk("basic_single_last", 64'(last_cnt - l0), 64'd1);
        chk("basic_busy_low", 64'(busy), 64'd0);

        // Backpressure: issues stop at FIFO depth
        rdy_mode = 2;
        en0 = en_cnt;
        do_cmd(12'(($urandom_range(0, 4095))), 16, 1'b1);
        repeat (20) step();
        chk("bp_issue_stall", 64'(en_cnt - en0), 64'(FD));
        rdy_mode = 0;
        wait_done(100, "bp_done");
        chk("bp_total_issue", 64'(en_cnt - en0), 64'd16);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Address wrap
        addr_log.delete();
        do_cmd(12'hFFE, 4, 1'b1);
        wait_done(40, "wrap_done");
        chk("wrap_issue_count", 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            chk("wrap_addr0", 64'(addr_log[0]), 64'h0FFE);
            chk("wrap_addr1", 64'(addr_log[1]), 64'h0FFF);
            chk("wrap_addr2", 64'(addr_log[2]), 64'h0000);
            chk("wrap_addr3", 64'(addr_log[3]), 64'h0001);
        end

        // Zero length
        en0 = en_cnt;
        v0 = valid_cnt;
        do_cmd(12'h123, 0, 1'b0);
        chk("zero_done_pulse", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        step();
        chk("zero_done_one_cycle", 64'(done), 64'd0);
        repeat (5) step();
        chk("zero_no_mem_en", 64'(en_cnt - en0), 64'd0);
        chk("zero_no_valid", 64'(valid_cnt - v0), 64'd0);

        // Start while busy is ignored
        p0 = pop_cnt;
        d0 = done_cnt;
        b = 12'($urandom_range(0, 4095));
        do_cmd(b, 8, 1'b1);
        step();
        start = 1'b1;
        base_addr = 12'h000;
        len = 13'd5;
        step();
        start = 1'b0;
        wait_done(60, "busy_start_done");
        repeat (20) step();
        chk("busy_start_beats", 64'(pop_cnt - p0), 64'd8);
        chk("busy_start_done_count", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-transfer
        do_cmd(12'($urandom_range(0, 4095)), 10, 1'b1);
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        chk("midrst_saw_valid", 64'(m_valid), 64'd1);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk_all_zero("midrst_async");
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        v0 = valid_cnt;
        d0 = done_cnt;
        repeat (10) step();
        chk("midrst_no_valid", 64'(valid_cnt - v0), 64'd0);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        p0 = pop_cnt;
        do_cmd(12'($urandom_range(0, 4095)), 2, 1'b1);
        wait_done(40, "midrst_new_done");
        chk("midrst_new_beats", 64'(pop_cnt - p0), 64'd2);

        // Full memory with random ready
        rdy_mode = 1;
        max_inflight = 0;
        p0 = pop_cnt;
        l0 = last_cnt;
        do_cmd(12'h000, 4096, 1'b1);
        wait_done(20000, "full_done");
        rdy_mode = 0;
        chk("full_beats", 64'(pop_cnt - p0), 64'd4096);
        chk("full_single_last", 64'(last_cnt - l0), 64'd1);
        chk("full_occupancy_bound", 64'(max_inflight <= FD), 64'd1);
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);
        step();
        chk("full_busy_low", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
